sdram_arbiter: RTL

- Two-port arbiter and transaction sequencer in front of the SDRAM controller's application interface, clocked on the system clk domain.
- Lets two requesters share the controller. Typical requesters are the wishbone slave and a DMA/video reader.
- Requests are granted round-robin. The arbiter drives app_write_enable/app_read_enable/app_address for the granted port, muxes that port's FIFO pulses and data, counts words to close each transaction, then enforces a turnaround gap before the next grant.

---
 rtl/sdram_arbiter_if.sv | 48 ++++
 rtl/sdram_arbiter.sv | 109 ++++++++++
 2 files changed

// File: rtl/sdram_arbiter_if.sv
// Requester-pair plus controller application-side bus for the SDRAM arbiter.
// master = arbiter view, slave = requesters/controller view.
interface sdram_arbiter_if #(
  parameter int LEN_WIDTH = 24
);
  logic                 sdram_ready;
  logic                 a_req, b_req;
  logic                 a_write, b_write;
  logic [21:0]          a_address, b_address;
  logic [LEN_WIDTH-1:0] a_length, b_length;
  logic                 a_grant, b_grant;
  logic                 a_done, b_done;
  logic                 a_wr_pulse, b_wr_pulse;
  logic [31:0]          a_wr_data, b_wr_data;
  logic [3:0]           a_wr_mask, b_wr_mask;
  logic                 a_wr_full, b_wr_full;
  logic                 a_rd_pulse, b_rd_pulse;
  logic                 a_rd_empty, b_rd_empty;
  logic [31:0]          rd_data;
  logic                 app_write_enable, app_read_enable;
  logic [21:0]          app_address;
  logic                 app_write_pulse;
  logic [31:0]          app_write_data;
  logic [3:0]           app_write_mask;
  logic                 app_read_pulse;
  logic [31:0]          app_read_data;
  logic                 write_fifo_full, read_fifo_empty;

  modport master (
    input  sdram_ready, a_req, b_req, a_write, b_write, a_address, b_address,
           a_length, b_length, a_wr_pulse, b_wr_pulse, a_wr_data, b_wr_data,
           a_wr_mask, b_wr_mask, a_rd_pulse, b_rd_pulse, app_read_data,
           write_fifo_full, read_fifo_empty,
    output a_grant, b_grant, a_done, b_done, a_wr_full, b_wr_full,
           a_rd_empty, b_rd_empty, rd_data, app_write_enable, app_read_enable,
           app_address, app_write_pulse, app_write_data, app_write_mask, app_read_pulse
  );

  modport slave (
    output sdram_ready, a_req, b_req, a_write, b_write, a_address, b_address,
           a_length, b_length, a_wr_pulse, b_wr_pulse, a_wr_data, b_wr_data,
           a_wr_mask, b_wr_mask, a_rd_pulse, b_rd_pulse, app_read_data,
           write_fifo_full, read_fifo_empty,
    input  a_grant, b_grant, a_done, b_done, a_wr_full, b_wr_full,
           a_rd_empty, b_rd_empty, rd_data, app_write_enable, app_read_enable,
           app_address, app_write_pulse, app_write_data, app_write_mask, app_read_pulse
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin two-port arbiter/sequencer for the SDRAM controller app interface.
// Grant 1 cycle after request, done 1 cycle after last accepted word; FIFO status forced busy when not owner.
module sdram_arbiter #(
  parameter int LEN_WIDTH  = 24,
  parameter int TURNAROUND = 4
) (
  input  logic            clk,
  input  logic            rst,
  sdram_arbiter_if.master bus
);
  localparam int TW = (TURNAROUND < 1) ? 1 : $clog2(TURNAROUND + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, RELEASE} state_t;

  state_t               state;
  logic                 grant_a, grant_b, done_a, done_b;
  logic                 wen, ren, last_b, lat_write;
  logic [21:0]          addr;
  logic [LEN_WIDTH-1:0] len_q, cnt;
  logic [TW-1:0]        ta;

  logic own_a, own_b, wr_acc, rd_acc, acc, own_req, pick_a, close;

  // Datapath ownership only while sequencing; a zero-length grant never reaches the controller.
  assign own_a = (state == ACTIVE) && grant_a;
  assign own_b = (state == ACTIVE) && grant_b;

  assign bus.app_write_pulse = (own_a && bus.a_wr_pulse) || (own_b && bus.b_wr_pulse);
  assign bus.app_read_pulse  = (own_a && bus.a_rd_pulse) || (own_b && bus.b_rd_pulse);
  assign bus.app_write_data  = own_a ? bus.a_wr_data : (own_b ? bus.b_wr_data : '0);
  assign bus.app_write_mask  = own_a ? bus.a_wr_mask : (own_b ? bus.b_wr_mask : '0);
  assign bus.a_wr_full       = own_a ? bus.write_fifo_full : 1'b1;
  assign bus.b_wr_full       = own_b ? bus.write_fifo_full : 1'b1;
  assign bus.a_rd_empty      = own_a ? bus.read_fifo_empty : 1'b1;
  assign bus.b_rd_empty      = own_b ? bus.read_fifo_empty : 1'b1;
  assign bus.rd_data         = bus.app_read_data;

  assign wr_acc  = bus.app_write_pulse && !bus.write_fifo_full;
  assign rd_acc  = bus.app_read_pulse && !bus.read_fifo_empty;
  assign acc     = lat_write ? wr_acc : rd_acc;
  assign own_req = grant_a ? bus.a_req : bus.b_req;
  assign pick_a  = bus.a_req && (!bus.b_req || last_b);

  // Either a zero-length grant waiting to retire, or an active burst finishing/aborting.
  assign close = ((state == IDLE) && (grant_a || grant_b)) ||
                 ((state == ACTIVE) && (((cnt + LEN_WIDTH'(acc)) == len_q) ||
                                        !own_req || !bus.sdram_ready));

  assign bus.a_grant          = grant_a;
  assign bus.b_grant          = grant_b;
  assign bus.a_done           = done_a;
  assign bus.b_done           = done_b;
  assign bus.app_write_enable = wen;
  assign bus.app_read_enable  = ren;
  assign bus.app_address      = addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant_a   <= 1'b0;
      grant_b   <= 1'b0;
      done_a    <= 1'b0;
      done_b    <= 1'b0;
      wen       <= 1'b0;
      ren       <= 1'b0;
      addr      <= '0;
      cnt       <= '0;
      len_q     <= '0;
      lat_write <= 1'b0;
      ta        <= '0;
      last_b    <= 1'b1;
    end else begin
      done_a <= 1'b0;
      done_b <= 1'b0;
      if (ta != '0) ta <= ta - TW'(1);
      if (close) begin
        grant_a <= 1'b0;
        grant_b <= 1'b0;
        wen     <= 1'b0;
        ren     <= 1'b0;
        done_a  <= grant_a;
        done_b  <= grant_b;
        last_b  <= grant_b;
        ta      <= TW'(TURNAROUND);
        state   <= (state == ACTIVE) ? RELEASE : IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (bus.sdram_ready && (ta == '0) && (bus.a_req || bus.b_req)) begin
              grant_a   <= pick_a;
              grant_b   <= !pick_a;
              lat_write <= pick_a ? bus.a_write : bus.b_write;
              addr      <= pick_a ? bus.a_address : bus.b_address;
              len_q     <= pick_a ? bus.a_length : bus.b_length;
              cnt       <= '0;
              if ((pick_a ? bus.a_length : bus.b_length) != '0) state <= ACTIVE;
            end
          end
          ACTIVE: begin
            cnt <= cnt + LEN_WIDTH'(acc);
            wen <= lat_write;
            ren <= !lat_write;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
